signal_watchdog_mc: RTL and testbench
=====================================

# signal_watchdog_mc

Multi-channel, parametrised successor to the single-channel receiver watchdog. It sits beside the OFDM receiver front end and watches NUM_CH I/Q streams for DC/stuck-sign conditions using per-component sign running sums over an internal window. DC detection requires a configurable persistence count before it trips, and the watchdog also checks the SIGNAL-field length. Any trip produces a stretched `receiver_rst` pulse, sets sticky cause bits and increments an event counter; the DC path then re-arms after the window refills.

## Interface
Parameters:
- IQ_DATA_WIDTH, 16, signed width of each I or Q sample
- NUM_CH, 2, number of I/Q channels (1..8)
- LOG2_SUM_LEN, 6, window length W = 2^LOG2_SUM_LEN samples
- RST_HOLD_LEN, 16, minimum `receiver_rst` high time in cycles (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- enable  in  1  enables the DC path; the length check is always active
- iq_data  in  NUM_CH*2*IQ_DATA_WIDTH  channel c at [c*2W+:2W], {q,i}, i in LSBs
- iq_valid  in  1  all channels' samples valid this cycle
- signal_len  in  16  decoded SIGNAL length
- sig_valid  in  1  signal_len valid (single-cycle)
- min_signal_len_th / max_signal_len_th  in  16 each  legal length bounds, inclusive
- dc_running_sum_th  in  LOG2_SUM_LEN+2  unsigned DC threshold on |sum|
- dc_persist_th  in  8  consecutive DC samples required to trip; 0 behaves as 1
- mode_all  in  1  0 = trip if any channel is DC; 1 = trip only if all channels are DC
- clr_status  in  1  clears rst_cause and rst_count
- receiver_rst  out  1  registered reset request to the receiver
- rst_cause  out  3  sticky: [0] DC, [1] length < min, [2] length > max
- rst_count  out  16  saturating count of HOLD entries

## Operation
- Sign map, per component: sample > 0 gives +1, < 0 gives -1, == 0 gives dither. Dither is one shared 2-bit register: reset value +1, toggles ±1 on every iq_valid.
- Window, per component: a W-deep delay line of 2-bit signs and a signed sum of LOG2_SUM_LEN+2 bits.
  - On iq_valid: sum <= sum + new - oldest.
  - The delay line clears to 0, so the first W samples only add.
  - The sum can never overflow, because |sum| <= W.
- |sum| is computed in the same width. `dc_ch[c]` = |sum_i| >= th OR |sum_q| >= th. `dc_agg` = OR or AND of `dc_ch` according to `mode_all`.
- Fill counter counts accepted samples up to W.
- States:
  - FILL: DC path inactive. Moves to ARMED when the fill count reaches W.
  - ARMED: on each registered valid (valid_d1), persist <= dc_agg ? sat255(persist+1) : 0. When persist_next >= max(dc_persist_th,1), set DC trip and go to HOLD.
  - HOLD: hold counter loads RST_HOLD_LEN-1 and counts down. At 0, go to FILL. On entry to HOLD, sums, delay lines, fill count and persist all clear. iq samples are ignored in HOLD.
- Length trip: sig_valid && (len < min || len > max). It applies in any state.
  - From FILL or ARMED it enters HOLD.
  - In HOLD it reloads the hold counter and does not increment rst_count.
- enable=0: forces FILL, keeps the window cleared and suppresses the DC trip. An active HOLD still completes.
- `receiver_rst` = registered (state == HOLD).
- rst_cause bits set on their trip. rst_count increments on each entry to HOLD from FILL or ARMED and saturates at 0xFFFF.
- clr_status clears rst_cause and rst_count. A trip in the same cycle wins: its bit is set and rst_count = 1.
- rst: state FILL, all sums/lines/counters 0, dither +1, receiver_rst 0, rst_cause 0, rst_count 0. Applies immediately, including mid-HOLD.

## Timing
- iq_valid at cycle t: sums update at t+1, persist updates at t+1 edge. If it trips, state = HOLD at t+2 and receiver_rst = 1 at t+2, because it is registered from the state.
- Length check: sig_valid at t gives receiver_rst = 1 at t+2.
- receiver_rst stays high exactly RST_HOLD_LEN cycles after its last (re)load.
- iq_valid may be asserted every cycle, with no back-pressure.

## Test plan
- DC trip: NUM_CH=2, W=64, th=60, persist=4, mode_all=0. ch0 I = +100 constant, all other components alternate ±100. Required: no trip through sample 66. Trip on sample 67; receiver_rst high 2 cycles later for 16 cycles; rst_cause=001; rst_count=1. Re-trip after a further 67 samples.
- All-zero input for 2000 samples, th=2 -> receiver_rst never asserts; |sums| <= 1.
- mode_all=1, ch0 DC only -> no trip. Then ch1 also DC -> trip after 4 samples in which both channels are DC.
- Length: min 14, max 4095. len=10 -> receiver_rst at t+2, cause=010. len=5000 -> cause bit2. len=100 -> no reset. A len trip during HOLD extends HOLD and rst_count is unchanged.
- Persistence break: DC true for 3 samples, false for 1, true for 3 -> no trip. dc_persist_th=0 trips on the first DC sample.
- rst asserted mid-HOLD -> receiver_rst=0 next cycle, all status 0. clr_status in the same cycle as a trip -> cause set, count=1.

Source files
------------

// File: rtl/signal_watchdog_mc_if.sv
// Bus bundle for signal_watchdog_mc: I/Q stream, SIGNAL length, thresholds/config and status.
// The front end (master) drives samples and configuration; the watchdog (slave) returns reset/status.
interface signal_watchdog_mc_if #(
    parameter int IQ_DATA_WIDTH = 16,
    parameter int NUM_CH        = 2,
    parameter int LOG2_SUM_LEN  = 6
);
    logic                              enable;
    logic [NUM_CH*2*IQ_DATA_WIDTH-1:0] iq_data;
    logic                              iq_valid;
    logic [15:0]                       signal_len;
    logic                              sig_valid;
    logic [15:0]                       min_signal_len_th;
    logic [15:0]                       max_signal_len_th;
    logic [LOG2_SUM_LEN+1:0]           dc_running_sum_th;
    logic [7:0]                        dc_persist_th;
    logic                              mode_all;
    logic                              clr_status;
    logic                              receiver_rst;
    logic [2:0]                        rst_cause;
    logic [15:0]                       rst_count;

    modport master (
        output enable, iq_data, iq_valid, signal_len, sig_valid,
        output min_signal_len_th, max_signal_len_th, dc_running_sum_th,
        output dc_persist_th, mode_all, clr_status,
        input  receiver_rst, rst_cause, rst_count
    );

    modport slave (
        input  enable, iq_data, iq_valid, signal_len, sig_valid,
        input  min_signal_len_th, max_signal_len_th, dc_running_sum_th,
        input  dc_persist_th, mode_all, clr_status,
        output receiver_rst, rst_cause, rst_count
    );
endinterface

// File: rtl/signal_watchdog_mc.sv
// Multi-channel receiver watchdog: per-component sign running sums detect DC/stuck-sign input,
// SIGNAL length is range-checked, and any trip produces a stretched receiver reset pulse.
module signal_watchdog_mc #(
    parameter int IQ_DATA_WIDTH = 16,
    parameter int NUM_CH        = 2,
    parameter int LOG2_SUM_LEN  = 6,
    parameter int RST_HOLD_LEN  = 16
) (
    input  logic                clk,
    input  logic                rst,
    signal_watchdog_mc_if.slave bus
);
    localparam int W  = 1 << LOG2_SUM_LEN;
    localparam int SW = LOG2_SUM_LEN + 2;
    localparam int NC = 2 * NUM_CH;
    localparam int FW = LOG2_SUM_LEN + 1;
    localparam int HW = (RST_HOLD_LEN > 1) ? $clog2(RST_HOLD_LEN) : 1;

    localparam logic [FW-1:0] FILL_FULL = FW'(W);
    localparam logic [FW-1:0] FILL_LAST = FW'(W - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(RST_HOLD_LEN - 1);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_ARMED = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [FW-1:0]   fill_q, fill_d;
    logic [7:0]      persist_q, persist_d;
    logic [7:0]      persist_inc;
    logic [7:0]      persist_nx;
    logic [7:0]      persist_min;
    logic            valid_d1_q;
    logic [1:0]      dither_q;
    logic            len_trip_q;
    logic [1:0]      len_cause_q;
    logic            receiver_rst_q;
    logic [2:0]      rst_cause_q, rst_cause_d;
    logic [15:0]     rst_count_q, rst_count_d;

    logic            len_lt;
    logic            len_gt;
    logic            dc_trip;
    logic            enter_hold;
    logic            win_clr;
    logic            accept;
    logic [NC-1:0]   comp_dc;
    logic [NUM_CH-1:0] dc_ch;
    logic            dc_agg;

    // ------------------------------------------------------------------
    // Control terms shared by the window and the FSM
    // ------------------------------------------------------------------
    assign len_lt      = bus.signal_len < bus.min_signal_len_th;
    assign len_gt      = bus.signal_len > bus.max_signal_len_th;
    assign persist_min = (bus.dc_persist_th == 8'd0) ? 8'd1 : bus.dc_persist_th;
    assign persist_inc = (persist_q == 8'hFF) ? 8'hFF : persist_q + 8'd1;
    assign persist_nx  = dc_agg ? persist_inc : 8'd0;

    assign dc_trip    = (state_q == S_ARMED) && bus.enable && valid_d1_q &&
                        (persist_nx >= persist_min);
    assign enter_hold = (state_q != S_HOLD) && (dc_trip || len_trip_q);
    // Window stays cleared while disabled and is wiped on every HOLD entry.
    assign win_clr    = enter_hold || ((state_q != S_HOLD) && !bus.enable);
    assign accept     = bus.iq_valid && bus.enable && (state_q != S_HOLD) && !enter_hold;

    // ------------------------------------------------------------------
    // Per-component sign window
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NC; gi++) begin : g_comp
        logic signed [IQ_DATA_WIDTH-1:0] samp;
        logic [1:0]    sign_new;
        logic [1:0]    line_q [W];
        logic [SW-1:0] sum_q;
        logic [SW-1:0] sum_abs;
        logic [SW-1:0] ext_new;
        logic [SW-1:0] ext_old;

        assign samp = bus.iq_data[gi*IQ_DATA_WIDTH +: IQ_DATA_WIDTH];

        always_comb begin
            sign_new = dither_q;
            if (samp[IQ_DATA_WIDTH-1]) begin
                sign_new = 2'b11;
            end else if (|samp) begin
                sign_new = 2'b01;
            end
        end

        assign ext_new = {{(SW-2){sign_new[1]}}, sign_new};
        assign ext_old = {{(SW-2){line_q[W-1][1]}}, line_q[W-1]};

        always_ff @(posedge clk) begin
            if (rst || win_clr) begin
                sum_q <= '0;
                for (int i = 0; i < W; i++) begin
                    line_q[i] <= 2'b00;
                end
            end else if (accept) begin
                line_q[0] <= sign_new;
                for (int i = 1; i < W; i++) begin
                    line_q[i] <= line_q[i-1];
                end
                sum_q <= sum_q + ext_new - ext_old;
            end
        end

        // |sum| <= W always fits in SW bits, so the negate cannot wrap.
        assign sum_abs     = sum_q[SW-1] ? (~sum_q + 1'b1) : sum_q;
        assign comp_dc[gi] = (sum_abs >= bus.dc_running_sum_th);
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
        assign dc_ch[gi] = comp_dc[2*gi] | comp_dc[2*gi+1];
    end

    assign dc_agg = bus.mode_all ? (&dc_ch) : (|dc_ch);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FILL;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            S_FILL: begin
                if (accept && (fill_q == FILL_LAST)) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                state_d = S_ARMED;
            end
            S_HOLD: begin
                if (len_trip_q) begin
                    hold_cnt_d = HOLD_LOAD;
                end else if (hold_cnt_q == '0) begin
                    state_d = S_FILL;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
        if (state_q != S_HOLD) begin
            if (enter_hold) begin
                state_d    = S_HOLD;
                hold_cnt_d = HOLD_LOAD;
            end else if (!bus.enable) begin
                state_d = S_FILL;
            end
        end
    end

    // ------------------------------------------------------------------
    // Fill count and DC persistence
    // ------------------------------------------------------------------
    always_comb begin
        fill_d = fill_q;
        if (win_clr) begin
            fill_d = '0;
        end else if (accept && (fill_q != FILL_FULL)) begin
            fill_d = fill_q + 1'b1;
        end
    end

    always_comb begin
        persist_d = persist_q;
        if ((state_q == S_ARMED) && valid_d1_q) begin
            persist_d = persist_nx;
        end
        if (enter_hold || (state_d != S_ARMED)) begin
            persist_d = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q      <= '0;
            persist_q   <= 8'd0;
            valid_d1_q  <= 1'b0;
            dither_q    <= 2'b01;
            len_trip_q  <= 1'b0;
            len_cause_q <= 2'b00;
        end else begin
            fill_q      <= fill_d;
            persist_q   <= persist_d;
            valid_d1_q  <= accept;
            // +1 <-> -1 on every valid, independent of state
            if (bus.iq_valid) begin
                dither_q <= ~dither_q + 2'b01;
            end
            len_trip_q  <= bus.sig_valid && (len_lt || len_gt);
            len_cause_q <= bus.sig_valid ? {len_gt, len_lt} : 2'b00;
        end
    end

    // ------------------------------------------------------------------
    // Status and reset output
    // ------------------------------------------------------------------
    always_comb begin
        rst_cause_d = bus.clr_status ? 3'b000 : rst_cause_q;
        rst_count_d = bus.clr_status ? 16'd0 : rst_count_q;
        rst_cause_d = rst_cause_d | {len_cause_q, dc_trip};
        if (enter_hold && (rst_count_d != 16'hFFFF)) begin
            rst_count_d = rst_count_d + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            receiver_rst_q <= 1'b0;
            rst_cause_q    <= 3'b000;
            rst_count_q    <= 16'd0;
        end else begin
            receiver_rst_q <= (state_d == S_HOLD);
            rst_cause_q    <= rst_cause_d;
            rst_count_q    <= rst_count_d;
        end
    end

    assign bus.receiver_rst = receiver_rst_q;
    assign bus.rst_cause    = rst_cause_q;
    assign bus.rst_count    = rst_count_q;

endmodule

// File: tb/tb_signal_watchdog_mc.sv
// Scoreboard bench for signal_watchdog_mc: stimulus pushes expected reset events,
// a monitor pops and checks them on every receiver_rst rising edge.
module tb_signal_watchdog_mc;
    logic clk;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   rises_seen = 0;
    int   rises_exp = 0;

    typedef struct {
        int          at_cyc;
        logic [2:0]  cause;
        logic [15:0] cnt;
        int          len;
    } ev_t;

    ev_t  exp_q[$];
    ev_t  ev;
    logic mon_prev;
    int   mon_high;
    int   mon_len;

    signal_watchdog_mc_if #(.IQ_DATA_WIDTH(16), .NUM_CH(2), .LOG2_SUM_LEN(6)) bus ();

    signal_watchdog_mc #(
        .IQ_DATA_WIDTH(16),
        .NUM_CH(2),
        .LOG2_SUM_LEN(6),
        .RST_HOLD_LEN(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d (cyc=%0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int at_cyc, input logic [2:0] cause, input logic [15:0] cnt,
                           input int len);
        ev_t e;
        e.at_cyc = at_cyc;
        e.cause  = cause;
        e.cnt    = cnt;
        e.len    = len;
        exp_q.push_back(e);
        rises_exp++;
    endtask

    // ch0 I constant +100; everything else alternates +/-100 unless ch1 I is forced DC.
    task automatic set_iq(input int k, input bit ch1_dc);
        logic signed [15:0] alt;
        logic signed [15:0] c1i;
        alt = ((k % 2) == 1) ? 16'sd100 : -16'sd100;
        c1i = ch1_dc ? 16'sd100 : alt;
        bus.iq_data = {alt, c1i, alt, 16'sd100};
    endtask

    task automatic send_slow(input int k, input int th, input bit exp_trip);
        set_iq(k, 1'b0);
        bus.dc_running_sum_th = 8'(th);
        bus.iq_valid = 1'b1;
        if (exp_trip) push_ev(cyc + 2, 3'b001, 16'd1, 16);
        tick();
        bus.iq_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic send_len(input logic [15:0] len);
        bus.signal_len = len;
        bus.sig_valid  = 1'b1;
        tick();
        bus.sig_valid  = 1'b0;
    endtask

    // Monitor: every rising receiver_rst is one transaction.
    initial begin
        mon_prev = 1'b0;
        mon_high = 0;
        mon_len  = 0;
        forever begin
            @(negedge clk);
            if (bus.receiver_rst && !mon_prev) begin
                rises_seen++;
                $display("event: receiver_rst rise cyc=%0d cause=%03b count=%0d",
                         cyc, bus.rst_cause, bus.rst_count);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rst: got rise at cyc=%0d required none", cyc);
                    mon_len = 0;
                end else begin
                    ev = exp_q.pop_front();
                    check("rise_cycle", cyc, ev.at_cyc);
                    check("rst_cause", {29'd0, bus.rst_cause}, {29'd0, ev.cause});
                    check("rst_count", {16'd0, bus.rst_count}, {16'd0, ev.cnt});
                    mon_len = ev.len;
                end
                mon_high = 1;
            end else if (bus.receiver_rst) begin
                mon_high++;
            end else if (mon_prev && (mon_len != 0)) begin
                check("hold_len", mon_high, mon_len);
            end
            mon_prev = bus.receiver_rst;
        end
    end

    initial begin
        int p;
        rst                   = 1'b1;
        bus.enable            = 1'b1;
        bus.iq_data           = '0;
        bus.iq_valid          = 1'b0;
        bus.signal_len        = 16'd0;
        bus.sig_valid         = 1'b0;
        bus.min_signal_len_th = 16'd14;
        bus.max_signal_len_th = 16'd4095;
        bus.dc_running_sum_th = 8'd60;
        bus.dc_persist_th     = 8'd4;
        bus.mode_all          = 1'b0;
        bus.clr_status        = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("reset_receiver_rst", {31'd0, bus.receiver_rst}, 32'd0);
        check("reset_rst_cause", {29'd0, bus.rst_cause}, 32'd0);
        check("reset_rst_count", {16'd0, bus.rst_count}, 32'd0);

        // All-zero input: dither keeps |sum| <= 1, never reaches th=2
        bus.dc_running_sum_th = 8'd2;
        bus.iq_data  = '0;
        bus.iq_valid = 1'b1;
        repeat (2000) tick();
        bus.iq_valid = 1'b0;
        repeat (5) tick();
        check("zero_input_no_trip", rises_seen, 0);

        bus.enable = 1'b0;
        tick();
        tick();
        bus.enable = 1'b1;
        bus.dc_running_sum_th = 8'd60;

        // DC trip on sample 67, re-trip 67 accepted samples after HOLD ends
        p = cyc;
        push_ev(p + 68, 3'b001, 16'd1, 16);
        push_ev(p + 152, 3'b001, 16'd2, 16);
        for (int k = 1; k <= 151; k++) begin
            set_iq(k, 1'b0);
            bus.iq_valid = 1'b1;
            tick();
        end
        bus.iq_valid = 1'b0;
        repeat (25) tick();

        // mode_all: ch0 DC alone never trips; ch1 I turns DC at sample 81,
        // both channels DC from sample 140, trip on sample 143
        bus.clr_status = 1'b1;
        bus.enable     = 1'b0;
        tick();
        bus.clr_status = 1'b0;
        bus.enable     = 1'b1;
        bus.mode_all   = 1'b1;
        p = cyc;
        push_ev(p + 144, 3'b001, 16'd1, 16);
        for (int k = 1; k <= 143; k++) begin
            set_iq(k, k > 80);
            bus.iq_valid = 1'b1;
            tick();
        end
        bus.iq_valid = 1'b0;
        repeat (25) tick();

        // Persistence break: 3 DC, 1 not, 3 DC -> no trip; then persist_th=0 trips at once
        bus.clr_status = 1'b1;
        bus.enable     = 1'b0;
        bus.mode_all   = 1'b0;
        tick();
        bus.clr_status = 1'b0;
        bus.enable     = 1'b1;
        for (int k = 1; k <= 63; k++) begin
            set_iq(k, 1'b0);
            bus.iq_valid = 1'b1;
            tick();
        end
        bus.iq_valid = 1'b0;
        tick();
        send_slow(64, 60, 1'b0);
        send_slow(65, 60, 1'b0);
        send_slow(66, 60, 1'b0);
        send_slow(67, 127, 1'b0);
        send_slow(68, 60, 1'b0);
        send_slow(69, 60, 1'b0);
        send_slow(70, 60, 1'b0);
        check("persist_break_no_trip", rises_seen, rises_exp);
        send_slow(71, 127, 1'b0);
        bus.dc_persist_th = 8'd0;
        send_slow(72, 60, 1'b1);
        repeat (25) tick();
        bus.dc_persist_th     = 8'd4;
        bus.dc_running_sum_th = 8'd60;

        // Length checks
        bus.clr_status = 1'b1;
        tick();
        bus.clr_status = 1'b0;
        push_ev(cyc + 2, 3'b010, 16'd1, 16);
        send_len(16'd10);
        repeat (25) tick();
        push_ev(cyc + 2, 3'b110, 16'd2, 16);
        send_len(16'd5000);
        repeat (25) tick();
        send_len(16'd100);
        repeat (10) tick();
        check("legal_len_no_trip", rises_seen, rises_exp);

        // Length trip inside HOLD reloads the hold counter only
        p = cyc;
        push_ev(p + 2, 3'b110, 16'd3, 23);
        send_len(16'd10);
        repeat (6) tick();
        send_len(16'd10);
        repeat (30) tick();
        check("hold_extend_count", {16'd0, bus.rst_count}, 32'd3);

        // clr_status coincident with a trip: trip wins
        p = cyc;
        push_ev(p + 2, 3'b010, 16'd1, 16);
        send_len(16'd10);
        bus.clr_status = 1'b1;
        tick();
        bus.clr_status = 1'b0;
        repeat (25) tick();

        // rst mid-HOLD
        p = cyc;
        push_ev(p + 2, 3'b110, 16'd2, 0);
        send_len(16'd5000);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check("midhold_rst_receiver_rst", {31'd0, bus.receiver_rst}, 32'd0);
        check("midhold_rst_cause", {29'd0, bus.rst_cause}, 32'd0);
        check("midhold_rst_count", {16'd0, bus.rst_count}, 32'd0);
        rst = 1'b0;
        repeat (10) tick();

        check("all_events_seen", rises_seen, rises_exp);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
